// File: rtl/seq1_arb.sv
// seq1_arb: round-robin arbiter that time-shares one seq1 datapath among
// NREQ requesters. The datapath wants I[2:0] one cycle before I[3], so the
// winning vector is split across two pipeline stages. The requester ID
// travels alongside so each result comes back tagged with its owner.
module seq1_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] vec,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        dp_i,
  input  logic [2:0]        dp_s,
  output logic              res_vld,
  output logic [IDW-1:0]    res_id,
  output logic [2:0]        res_s
);

  // Unpacked view of the packed request vectors, one nibble per requester.
  logic [3:0] vec_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_vec
      assign vec_arr[gi] = vec[4*gi +: 4];
    end
  endgenerate

  // Round-robin pointer: search for a winner starts here.
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] ptr_next;

  // Arbitration results for the current cycle.
  logic           grant_any;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand;
  logic [3:0]     win_vec;

  // Pipeline state: A holds the whole vector, B only needs bit 3, C just
  // tracks ownership while the datapath computes.
  logic           a_vld_reg;
  logic [IDW-1:0] a_id_reg;
  logic [3:0]     a_vec_reg;
  logic           b_vld_reg;
  logic [IDW-1:0] b_id_reg;
  logic           b_bit3_reg;
  logic           c_vld_reg;
  logic [IDW-1:0] c_id_reg;
  logic           res_vld_reg;
  logic [IDW-1:0] res_id_reg;
  logic [2:0]     res_s_reg;

  // Scan requesters from ptr_reg upward with wrap; first set bit wins.
  always_comb begin
    grant_any = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_any && req[cand[IDW-1:0]]) begin
        grant_any = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
    // Enable and reset override any pending request.
    if (rst || !en) begin
      grant_any = 1'b0;
    end
  end

  // One-hot grant, winner's vector and the pointer value after this grant.
  always_comb begin
    gnt      = '0;
    win_vec  = vec_arr[win_id];
    ptr_next = ptr_reg;
    if (grant_any) begin
      gnt[win_id] = 1'b1;
      ptr_next    = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
    end
  end

  // Pointer advances only on cycles that actually grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (grant_any) begin
      ptr_reg <= ptr_next;
    end
  end

  // Skew pipeline; empty stages carry zeros so the datapath sees 0 inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld_reg  <= 1'b0;
      a_id_reg   <= '0;
      a_vec_reg  <= '0;
      b_vld_reg  <= 1'b0;
      b_id_reg   <= '0;
      b_bit3_reg <= 1'b0;
      c_vld_reg  <= 1'b0;
      c_id_reg   <= '0;
    end else begin
      a_vld_reg  <= grant_any;
      a_id_reg   <= win_id;
      a_vec_reg  <= grant_any ? win_vec : 4'b0000;
      b_vld_reg  <= a_vld_reg;
      b_id_reg   <= a_id_reg;
      b_bit3_reg <= a_vec_reg[3];
      c_vld_reg  <= b_vld_reg;
      c_id_reg   <= b_id_reg;
    end
  end

  // Capture the datapath result with its owner; hold tag/value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_vld_reg <= 1'b0;
      res_id_reg  <= '0;
      res_s_reg   <= '0;
    end else begin
      res_vld_reg <= c_vld_reg;
      if (c_vld_reg) begin
        res_id_reg <= c_id_reg;
        res_s_reg  <= dp_s;
      end
    end
  end

  // I[3] comes from the older transaction in B, I[2:0] from the newer in A.
  assign dp_i    = {b_bit3_reg, a_vec_reg[2:0]};
  assign res_vld = res_vld_reg;
  assign res_id  = res_id_reg;
  assign res_s   = res_s_reg;

endmodule

// File: tb/tb_seq1_arb.sv
// Bench for seq1_arb: a small stand-in seq1 datapath, a transaction-level
// reference model with a cycle-stamped scoreboard, and directed stimulus
// with hand-computed literal expectations.
module tb_seq1_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] vec;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        dp_i;
  logic [2:0]        dp_s;
  logic              res_vld;
  logic [IDW-1:0]    res_id;
  logic [2:0]        res_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq1_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .vec     (vec),
    .gnt     (gnt),
    .dp_i    (dp_i),
    .dp_s    (dp_s),
    .res_vld (res_vld),
    .res_id  (res_id),
    .res_s   (res_s)
  );

  // Stand-in seq1 function of one whole 4-bit vector.
  function automatic logic [2:0] seq1_f(input logic b3, input logic [2:0] lo);
    return 3'b110 ^ (b3 ? {1'b0, lo[0], lo[0] ^ lo[1]} : 3'b000);
  endfunction

  // Stand-in datapath: I[2:0] registered one cycle earlier than I[3].
  logic [2:0] dp_lo1, dp_lo2;
  logic       dp_hi;
  always @(posedge clk) begin
    dp_lo1 <= dp_i[2:0];
    dp_lo2 <= dp_lo1;
    dp_hi  <= dp_i[3];
  end
  assign dp_s = seq1_f(dp_hi, dp_lo2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         id;
    logic [3:0] v;
    int         due;
  } txn_t;

  txn_t           sb[$];
  int             ptr_m    = 0;
  int             cyc      = 0;
  int             last_rst = -100;
  bit             seen_rst = 1'b0;
  logic           gv   [16];
  logic [3:0]     gvec [16];
  logic [IDW-1:0] held_id = '0;
  logic [2:0]     held_s  = '0;

  // Winner by the round-robin rule, or -1 if nobody is granted.
  function automatic int pick();
    if (rst !== 1'b0 || en !== 1'b1) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req[(ptr_m + k) % NREQ] === 1'b1) return (ptr_m + k) % NREQ;
    end
    return -1;
  endfunction

  // Compare every cycle, then record this cycle's grant into the model.
  always @(negedge clk) begin
    int             w;
    logic [NREQ-1:0] eg;
    logic           ev;
    logic [2:0]     elo;
    logic           eb3;
    txn_t           t;
    w  = pick();
    eg = (w >= 0) ? NREQ'(1 << w) : '0;
    if (seen_rst) begin
      check("gnt", 32'(gnt), 32'(eg));
      elo = (cyc - 1 > last_rst && gv[(cyc - 1) % 16]) ? gvec[(cyc - 1) % 16][2:0] : 3'b000;
      eb3 = (cyc - 2 > last_rst && gv[(cyc - 2) % 16]) ? gvec[(cyc - 2) % 16][3] : 1'b0;
      check("dp_i", 32'(dp_i), 32'({eb3, elo}));
      ev = (sb.size() > 0 && sb[0].due == cyc);
      if (ev) begin
        held_id = IDW'(sb[0].id);
        held_s  = seq1_f(sb[0].v[3], sb[0].v[2:0]);
        void'(sb.pop_front());
      end
      check("res_vld", 32'(res_vld), 32'(ev));
      check("res_id", 32'(res_id), 32'(held_id));
      check("res_s", 32'(res_s), 32'(held_s));
    end
    gv[cyc % 16]   = (w >= 0);
    gvec[cyc % 16] = (w >= 0) ? vec[4*w +: 4] : 4'b0000;
    if (w >= 0) begin
      t.id  = w;
      t.v   = vec[4*w +: 4];
      t.due = cyc + 4;
      sb.push_back(t);
      ptr_m = (w + 1) % NREQ;
    end
    if (rst === 1'b1) begin
      sb.delete();
      ptr_m    = 0;
      last_rst = cyc;
      held_id  = '0;
      held_s   = '0;
      seen_rst = 1'b1;
    end
    cyc++;
  end

  // ---------------- directed stimulus ----------------
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; vec = '0;
    next();
    next();
    @(negedge clk);
    check("rst_dp_i", 32'(dp_i), 32'h0);
    check("rst_res_vld", 32'(res_vld), 32'h0);
    check("rst_res_id", 32'(res_id), 32'h0);
    check("rst_res_s", 32'(res_s), 32'h0);
    next();
    rst = 1'b0; en = 1'b1;

    // Single request from requester 0, vector 1001 -> S=101 four cycles later.
    next();
    req = 4'b0001; vec[3:0] = 4'b1001;
    @(negedge clk);
    check("t1_gnt", 32'(gnt), 32'h1);
    next(); req = '0;
    next(); next(); next();
    @(negedge clk);
    check("t1_vld", 32'(res_vld), 32'h1);
    check("t1_id", 32'(res_id), 32'h0);
    check("t1_s", 32'(res_s), 32'h5);

    // Back-to-back 1111,0000,1111 from requester 1 exercises the I[3] skew.
    next();
    req = 4'b0010; vec[7:4] = 4'hF;
    @(negedge clk);
    check("t2_gnt", 32'(gnt), 32'h2);
    next(); vec[7:4] = 4'h0;
    next(); vec[7:4] = 4'hF;
    next(); req = '0;
    next();
    @(negedge clk);
    check("t2_s0", 32'(res_s), 32'h4);
    check("t2_id0", 32'(res_id), 32'h1);
    next();
    @(negedge clk);
    check("t2_s1", 32'(res_s), 32'h6);
    next();
    @(negedge clk);
    check("t2_s2", 32'(res_s), 32'h4);
    check("t2_vld2", 32'(res_vld), 32'h1);

    // PTR=2 with REQ=1011: 3, then 0, then 1 (requester 2 skipped).
    next();
    req = 4'b1011; vec = 16'($urandom);
    @(negedge clk);
    check("t4_gnt0", 32'(gnt), 32'h8);
    next(); vec = 16'($urandom);
    @(negedge clk);
    check("t4_gnt1", 32'(gnt), 32'h1);
    next(); vec = 16'($urandom);
    @(negedge clk);
    check("t4_gnt2", 32'(gnt), 32'h2);
    // Move the pointer back to 0 by granting requester 3 alone.
    next(); req = 4'b1000;
    @(negedge clk);
    check("t4_gnt3", 32'(gnt), 32'h8);
    next(); req = '0;

    // All four requesting for 8 cycles from PTR=0.
    for (int i = 0; i < 12; i++) begin
      next();
      req = (i < 8) ? 4'hF : 4'h0;
      vec = 16'($urandom);
      @(negedge clk);
      if (i < 8) check("t3_gnt", 32'(gnt), 32'(1 << (i % 4)));
      if (i >= 4) begin
        check("t3_vld", 32'(res_vld), 32'h1);
        check("t3_id", 32'((i - 4) % 4), 32'(res_id));
      end
    end

    // Two grants, then EN=0 for 5 cycles while everyone requests.
    next(); req = 4'hF; vec = 16'($urandom);
    @(negedge clk);
    check("t5_gnt0", 32'(gnt), 32'h1);
    next(); vec = 16'($urandom);
    next(); en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t5_gnt_off", 32'(gnt), 32'h0);
      if (j >= 2) check("t5_dp_i_drained", 32'(dp_i), 32'h0);
      next();
    end
    en = 1'b1;
    @(negedge clk);
    check("t5_gnt_resume", 32'(gnt), 32'h4);
    next(); req = '0;

    // Burst of three grants, then reset before any of them returns.
    next(); req = 4'hF; vec = 16'($urandom);
    @(negedge clk);
    check("t6_gnt0", 32'(gnt), 32'h8);
    next(); vec = 16'($urandom);
    next(); vec = 16'($urandom);
    next(); rst = 1'b1;
    @(negedge clk);
    check("t6_gnt_rst", 32'(gnt), 32'h0);
    next(); rst = 1'b0; req = '0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t6_no_vld", 32'(res_vld), 32'h0);
      next();
    end
    req = 4'b0100; vec[11:8] = 4'b1010;
    @(negedge clk);
    check("t6_gnt_post", 32'(gnt), 32'h4);
    next(); req = '0;
    next(); next(); next();
    @(negedge clk);
    check("t6_vld", 32'(res_vld), 32'h1);
    check("t6_id", 32'(res_id), 32'h2);
    check("t6_s", 32'(res_s), 32'h7);
    next(); next(); next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq1_arb.md
Name: seq1_arb

Overview:
- Round-robin arbiter and sequencer that shares one seq1 datapath instance among NREQ requesters.
- Accepts one 4-bit input vector per cycle from the winning requester and drives the datapath with the skew it needs: I[2:0] one cycle before I[3].
- Tracks each in-flight transaction's requester ID through the datapath latency and returns the 3-bit result S tagged with that ID.
- Sits between the requester blocks and the seq1 instance in the test top.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-ID width; must equal ceil(log2(NREQ)).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous reset, active-high.
- EN  input  1  arbitration enable; 0 blocks new grants, the pipeline keeps draining.
- REQ  input  NREQ  per-requester request, level.
- VEC  input  4*NREQ  request vectors; requester k uses VEC[4k+3:4k].
- GNT  output  NREQ  one-hot grant, combinational, same cycle as acceptance.
- DP_I  output  4  drives the datapath I[3:0]; registered.
- DP_S  input  3  datapath S[2:0].
- RES_VLD  output  1  result valid, one-cycle pulse per transaction.
- RES_ID  output  IDW  requester ID of the result.
- RES_S  output  3  result value.

Behaviour:
- Arbitration (combinational):
  - Search REQ starting at index PTR, ascending with wrap; the first set bit wins.
  - GNT is one-hot on the winner, and is 0 when EN=0, REQ=0, or RST=1.
  - A requester holding GNT=1 in a cycle has had its VEC consumed that cycle.
- PTR update: after a grant to index w, PTR <= (w+1) mod NREQ. PTR is unchanged on cycles with no grant.
- Pipeline for a grant in cycle t:
  - Stage A (edge end of t): A_VLD <= 1, A_ID <= w, A_VEC <= VEC[w].
  - Cycle t+1: DP_I[2:0] = A_VEC[2:0]. The datapath input flops capture it at the end of t+1.
  - Stage B (edge end of t+1): B_VLD, B_ID, B_BIT3 <= A_VLD, A_ID, A_VEC[3].
  - Cycle t+2: DP_I[3] = B_BIT3.
  - Stage C (end of t+2): C_VLD, C_ID <= B_VLD, B_ID. DP_S is valid in cycle t+3.
  - Result (end of t+3): RES_VLD <= C_VLD, RES_ID <= C_ID, RES_S <= DP_S.
  - RES_* are visible in cycle t+4, so latency from GNT to RES_VLD is 4 cycles.
- Throughput:
  - One transaction per cycle, fully pipelined.
  - DP_I[3] and DP_I[2:0] in the same cycle belong to different transactions (B and A respectively).
- Empty stages: when A_VLD=0, DP_I[2:0]=000. When B_VLD=0, DP_I[3]=0.
- When C_VLD=0, RES_VLD=0 and RES_ID/RES_S hold their previous values.
- Results return in grant order; no reordering.
- Reset, with RST=1 at an edge:
  - PTR=0.
  - All *_VLD=0.
  - A_VEC, B_BIT3, DP_I=0.
  - RES_VLD=0, RES_ID=0, RES_S=0.
- Reset mid-operation:
  - In-flight transactions are dropped; no RES_VLD for them.
  - Datapath flops have no reset. Their contents are ignored because the valid chain is cleared.
- EN deasserted mid-stream: no new grants; transactions already granted complete normally.
- REQ for a requester not granted must be held by the requester; the arbiter keeps no request memory.

Test Plan:
- Reset, then a single request REQ=0001 with VEC[3:0]=1001 → GNT=0001 in cycle t; RES_VLD=1, RES_ID=0, RES_S=101 in cycle t+4; RES_VLD=0 otherwise.
- Requester 1 drives 1111, then 0000, then 1111 on consecutive cycles (tests DP_I[3] skew):
  - Required: RES_S=100, 110, 100 on consecutive cycles, all with RES_ID=1.
  - Misaligned I[3] would give 110, 110, 110.
- REQ=1111 held for 8 cycles with PTR=0 → GNT sequence 0001, 0010, 0100, 1000, 0001, …; RES_ID sequence 0,1,2,3,0,… starting 4 cycles later.
- PTR=2, REQ=1011 → grants go to 3, then 0, then 1; PTR wraps correctly and requester 2 is skipped.
- EN=0 with REQ=1111 for 3 cycles → GNT=0, DP_I=0000 once the pipeline has drained, no RES_VLD; EN=1 restores grants from the current PTR.
- RST pulse two cycles after a burst of 3 grants → no RES_VLD for any of them; PTR=0; the first post-reset grant returns its correct result 4 cycles later.
